// File: rtl/pr_release_queue.sv
// Release queue between ROB retirement and the rename free list: compacts up to
// four retiring old PRs per cycle into a FIFO and presents up to four per cycle.
// Optional build macro: PR_RELEASE_ZERO_FILTER_EN (never recycle PR 0).
module pr_release_queue #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_ret_valid,
   input  logic [5:0] i_ret_pr0,
   input  logic [5:0] i_ret_pr1,
   input  logic [5:0] i_ret_pr2,
   input  logic [5:0] i_ret_pr3,
   output logic       o_ret_ready,
   input  logic       i_fl_hold,
   output logic [2:0] o_free_pr_num,
   output logic [5:0] o_free_pr_num_in0,
   output logic [5:0] o_free_pr_num_in1,
   output logic [5:0] o_free_pr_num_in2,
   output logic [5:0] o_free_pr_num_in3,
   output logic       o_overflow_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [5:0]    r_storage [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          r_overflowErr;

   logic [5:0] w_retPr [4];
   logic [3:0] w_slotValid;
   logic [2:0] w_slotOffset [4];
   logic [2:0] w_nIn;
   logic       w_retReady;
   logic       w_enq;
   logic       w_drop;
   logic [2:0] w_freeNum;
   logic [2:0] w_nOut;
   logic [5:0] w_present [4];

   assign w_retPr[0] = i_ret_pr0;
   assign w_retPr[1] = i_ret_pr1;
   assign w_retPr[2] = i_ret_pr2;
   assign w_retPr[3] = i_ret_pr3;

   always_comb begin
      w_slotValid = i_ret_valid;
`ifdef PR_RELEASE_ZERO_FILTER_EN
      // PR 0 is the hard-wired zero register and must never return to the free list
      for (int k = 0; k < 4; k++) begin
         if (w_retPr[k] == 6'd0) begin
            w_slotValid[k] = 1'b0;
         end
      end
`endif
   end

   // Each valid slot lands at wr_ptr plus the number of valid slots below it
   always_comb begin
      logic [2:0] acc;
      acc = 3'd0;
      for (int k = 0; k < 4; k++) begin
         w_slotOffset[k] = acc;
         acc = acc + {2'b00, w_slotValid[k]};
      end
      w_nIn = acc;
   end

   // Ready looks only at registered count; a same-cycle dequeue cannot raise it
   assign w_retReady = (r_count <= CW'(DEPTH - 4));
   assign w_enq      = (w_slotValid != 4'b0000) && w_retReady;
   assign w_drop     = (i_ret_valid != 4'b0000) && !w_retReady;
   assign w_freeNum  = (r_count >= CW'(4)) ? 3'd4 : r_count[2:0];
   assign w_nOut     = i_fl_hold ? 3'd0 : w_freeNum;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_present[k] = 6'd0;
         if (3'(k) < w_freeNum) begin
            w_present[k] = r_storage[r_rdPtr + AW'(k)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_enq) begin
         for (int k = 0; k < 4; k++) begin
            if (w_slotValid[k]) begin
               r_storage[r_wrPtr + AW'(w_slotOffset[k])] <= w_retPr[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr       <= '0;
         r_rdPtr       <= '0;
         r_count       <= '0;
         r_overflowErr <= 1'b0;
      end else begin
         if (w_enq) begin
            r_wrPtr <= r_wrPtr + AW'(w_nIn);
         end
         r_rdPtr <= r_rdPtr + AW'(w_nOut);
         r_count <= r_count + (w_enq ? CW'(w_nIn) : CW'(0)) - CW'(w_nOut);
         if (w_drop) begin
            r_overflowErr <= 1'b1;
         end
      end
   end

   assign o_ret_ready       = w_retReady;
   assign o_free_pr_num     = w_freeNum;
   assign o_free_pr_num_in0 = w_present[0];
   assign o_free_pr_num_in1 = w_present[1];
   assign o_free_pr_num_in2 = w_present[2];
   assign o_free_pr_num_in3 = w_present[3];
   assign o_overflow_err    = r_overflowErr;

endmodule

// File: tb/tb_pr_release_queue.sv
// Self-checking bench for pr_release_queue: table of directed vectors, hand-written
// wrap/simultaneous/zero-PR sequences and a random stream, all against a queue scoreboard.
module tb_pr_release_queue;

   localparam int DEPTH = 16;

   logic       clk;
   logic       rst;
   logic [3:0] retValid;
   logic [5:0] retPr0, retPr1, retPr2, retPr3;
   logic       retReady;
   logic       flHold;
   logic [2:0] freeNum;
   logic [5:0] freeIn0, freeIn1, freeIn2, freeIn3;
   logic       overflowErr;

   int testsRun;
   int failCount;

   logic [5:0] expQ[$];
   logic       mErr;

   typedef struct {
      logic [3:0] valid;
      logic [5:0] pr0;
      logic [5:0] pr1;
      logic [5:0] pr2;
      logic [5:0] pr3;
      logic       hold;
      int         expNum;
      logic       expReady;
      logic       expErr;
      logic [5:0] expIn0;
   } vec_t;

   vec_t vecs[11];

   pr_release_queue #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_ret_valid       (retValid),
      .i_ret_pr0         (retPr0),
      .i_ret_pr1         (retPr1),
      .i_ret_pr2         (retPr2),
      .i_ret_pr3         (retPr3),
      .o_ret_ready       (retReady),
      .i_fl_hold         (flHold),
      .o_free_pr_num     (freeNum),
      .o_free_pr_num_in0 (freeIn0),
      .o_free_pr_num_in1 (freeIn1),
      .o_free_pr_num_in2 (freeIn2),
      .o_free_pr_num_in3 (freeIn3),
      .o_overflow_err    (overflowErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string name, input int act, input int exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Compare every output against the scoreboard state
   task automatic checkOutput(input string tag);
      int n;
      logic [5:0] act [4];
      n = (expQ.size() > 4) ? 4 : expQ.size();
      act[0] = freeIn0; act[1] = freeIn1; act[2] = freeIn2; act[3] = freeIn3;
      compare({tag, ".num"}, int'(freeNum), n);
      compare({tag, ".ready"}, int'(retReady), (expQ.size() <= DEPTH - 4) ? 1 : 0);
      compare({tag, ".err"}, int'(overflowErr), int'(mErr));
      for (int k = 0; k < 4; k++) begin
         compare($sformatf("%s.in%0d", tag, k), int'(act[k]), (k < n) ? int'(expQ[k]) : 0);
      end
   endtask

   // Drive one cycle at negedge, update the scoreboard, advance to the next negedge
   task automatic applyStimulus(input logic [3:0] v, input logic [5:0] p0, input logic [5:0] p1,
                                input logic [5:0] p2, input logic [5:0] p3, input logic h);
      logic [5:0] pr [4];
      int nOut;
      bit ready;
      pr[0] = p0; pr[1] = p1; pr[2] = p2; pr[3] = p3;
      retValid = v; retPr0 = p0; retPr1 = p1; retPr2 = p2; retPr3 = p3; flHold = h;
      ready = (expQ.size() <= DEPTH - 4);
      nOut = h ? 0 : ((expQ.size() > 4) ? 4 : expQ.size());
      for (int k = 0; k < nOut; k++) void'(expQ.pop_front());
      if (v != 4'b0000) begin
         if (ready) begin
            for (int k = 0; k < 4; k++) begin
`ifdef PR_RELEASE_ZERO_FILTER_EN
               if (v[k] && pr[k] != 6'd0) expQ.push_back(pr[k]);
`else
               if (v[k]) expQ.push_back(pr[k]);
`endif
            end
         end else begin
            mErr = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      retValid = 4'b0000;
   endtask

   task automatic doReset();
      // Enqueue traffic during reset must be ignored
      rst = 1'b1;
      retValid = 4'b1111; retPr0 = 6'd1; retPr1 = 6'd2; retPr2 = 6'd3; retPr3 = 6'd4;
      flHold = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      retValid = 4'b0000;
      flHold = 1'b0;
      expQ.delete();
      mErr = 1'b0;
   endtask

   task automatic idle(input int cycles, input logic h);
      for (int i = 0; i < cycles; i++) applyStimulus(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, h);
   endtask

   initial begin
      testsRun = 0;
      failCount = 0;
      mErr = 1'b0;
      rst = 1'b1;
      retValid = 4'b0000;
      retPr0 = 6'd0; retPr1 = 6'd0; retPr2 = 6'd0; retPr3 = 6'd0;
      flHold = 1'b0;

      vecs[0]  = '{4'b1010, 6'd0,  6'd17, 6'd0,  6'd42, 1'b0, 2, 1'b1, 1'b0, 6'd17};
      vecs[1]  = '{4'b0000, 6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 0, 1'b1, 1'b0, 6'd0};
      vecs[2]  = '{4'b1111, 6'd16, 6'd17, 6'd18, 6'd19, 1'b1, 4, 1'b1, 1'b0, 6'd16};
      vecs[3]  = '{4'b1111, 6'd20, 6'd21, 6'd22, 6'd23, 1'b1, 4, 1'b1, 1'b0, 6'd16};
      vecs[4]  = '{4'b1111, 6'd24, 6'd25, 6'd26, 6'd27, 1'b1, 4, 1'b1, 1'b0, 6'd16};
      vecs[5]  = '{4'b1111, 6'd28, 6'd29, 6'd30, 6'd31, 1'b1, 4, 1'b0, 1'b0, 6'd16};
      vecs[6]  = '{4'b1111, 6'd60, 6'd61, 6'd62, 6'd63, 1'b1, 4, 1'b0, 1'b1, 6'd16};
      vecs[7]  = '{4'b0000, 6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 4, 1'b1, 1'b1, 6'd20};
      vecs[8]  = '{4'b0000, 6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 4, 1'b1, 1'b1, 6'd24};
      vecs[9]  = '{4'b0000, 6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 4, 1'b1, 1'b1, 6'd28};
      vecs[10] = '{4'b0000, 6'd0,  6'd0,  6'd0,  6'd0,  1'b0, 0, 1'b1, 1'b1, 6'd0};

      doReset();
      checkOutput("reset");
      compare("reset.readyConst", int'(retReady), 1);
      compare("reset.numConst", int'(freeNum), 0);

      // Directed table: sparse retire, fill to full, overflow drop, ordered drain
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].pr0, vecs[i].pr1, vecs[i].pr2, vecs[i].pr3, vecs[i].hold);
         compare($sformatf("vec%0d.num", i), int'(freeNum), vecs[i].expNum);
         compare($sformatf("vec%0d.ready", i), int'(retReady), int'(vecs[i].expReady));
         compare($sformatf("vec%0d.err", i), int'(overflowErr), int'(vecs[i].expErr));
         compare($sformatf("vec%0d.in0", i), int'(freeIn0), int'(vecs[i].expIn0));
         checkOutput($sformatf("vec%0d", i));
      end

      // Wrap: bring both pointers to 14, then a 4-wide write straddles 15 -> 0
      doReset();
      applyStimulus(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 1'b1);
      applyStimulus(4'b1111, 6'd5, 6'd6, 6'd7, 6'd8, 1'b1);
      applyStimulus(4'b1111, 6'd9, 6'd10, 6'd11, 6'd12, 1'b1);
      applyStimulus(4'b0011, 6'd13, 6'd14, 6'd0, 6'd0, 1'b1);
      checkOutput("preload");
      idle(4, 1'b0);
      checkOutput("preloadDrained");
      applyStimulus(4'b1111, 6'd50, 6'd51, 6'd52, 6'd53, 1'b1);
      compare("wrap.in0", int'(freeIn0), 50);
      compare("wrap.in1", int'(freeIn1), 51);
      compare("wrap.in2", int'(freeIn2), 52);
      compare("wrap.in3", int'(freeIn3), 53);
      checkOutput("wrap");
      idle(1, 1'b0);
      checkOutput("wrapDrained");

      // Simultaneous enqueue of 3 and dequeue of 4 at count 6
      applyStimulus(4'b1111, 6'd60, 6'd61, 6'd62, 6'd63, 1'b1);
      applyStimulus(4'b0101, 6'd33, 6'd0, 6'd34, 6'd0, 1'b1);
      checkOutput("count6");
      applyStimulus(4'b0111, 6'd40, 6'd41, 6'd42, 6'd0, 1'b0);
      compare("simul.num", int'(freeNum), 4);
      compare("simul.in0", int'(freeIn0), 33);
      compare("simul.in1", int'(freeIn1), 34);
      compare("simul.in2", int'(freeIn2), 40);
      checkOutput("simul");
      idle(2, 1'b0);
      checkOutput("simulDrained");

      // PR 0 handling
      doReset();
      applyStimulus(4'b0011, 6'd0, 6'd9, 6'd0, 6'd0, 1'b1);
`ifdef PR_RELEASE_ZERO_FILTER_EN
      compare("zero.num", int'(freeNum), 1);
      compare("zero.in0", int'(freeIn0), 9);
`else
      compare("zero.num", int'(freeNum), 2);
      compare("zero.in0", int'(freeIn0), 0);
      compare("zero.in1", int'(freeIn1), 9);
`endif
      checkOutput("zero");

      // Random stream with mixed hold, sparse masks and occasional overflow
      for (int i = 0; i < 300; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                       6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                       ($urandom_range(0, 99) < ((i < 150) ? 20 : 60)) ? 1'b1 : 1'b0);
         checkOutput($sformatf("rand%0d", i));
      end

      // Mid-stream reset clears everything including the sticky error
      doReset();
      checkOutput("midReset");

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
